can_crc_engine: RTL and testbench

Parametrised CAN/CAN FD receive-side CRC checker. Supports CRC-15 (classic), CRC-17 and CRC-21 (FD), selected per frame. Runs synchronously on `clk` with bit strobes as clock enables; no derived or gated clocks. Sits between the bit-destuffer/sampler and the ACK/error-frame logic, and drives the ACK slot and the CRC error report.

---
 rtl/can_crc_engine_if.sv | 43 ++++
 rtl/can_crc_engine.sv | 216 +++++++++++++++++++++
 tb/tb_can_crc_engine.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_crc_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : can_crc_engine_if
// Purpose  : Bundles the bit-level strobes, frame-control inputs and
//            check-result outputs of the CAN/CAN FD receive CRC checker.
// Ports    : master - the frame/bit-timing side; drives the strobes and
//                     frame control, observes the results.
//            slave  - the CRC checker itself.
// Revision : 1.0 - initial release
// ============================================================================
interface can_crc_engine_if;
  // Inputs to the checker
  logic        bit_valid;
  logic        tx_strobe;
  logic        rx_bit;
  logic        stuff_bit;
  logic        fixed_stuff;
  logic        sof;
  logic        end_crc;
  logic [1:0]  mode;
  logic        abort;
  logic        listen_only;
  // Outputs from the checker
  logic        ack_n;
  logic        crc_error;
  logic        delim_error;
  logic        crc_ok;
  logic [20:0] crc_value;
  logic        busy;

  modport master (
    output bit_valid, tx_strobe, rx_bit, stuff_bit, fixed_stuff, sof,
           end_crc, mode, abort, listen_only,
    input  ack_n, crc_error, delim_error, crc_ok, crc_value, busy
  );

  modport slave (
    input  bit_valid, tx_strobe, rx_bit, stuff_bit, fixed_stuff, sof,
           end_crc, mode, abort, listen_only,
    output ack_n, crc_error, delim_error, crc_ok, crc_value, busy
  );
endinterface
`default_nettype wire

// File: rtl/can_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : can_crc_engine
// Purpose  : Receive-side CRC checker for CAN (CRC-15) and CAN FD (CRC-17,
//            CRC-21). Shifts destuffed bits on bit_valid, checks the
//            register for zero at the end of the CRC field, drives the ACK
//            slot and reports CRC / delimiter errors.
// Ports    : clk        - system clock (strobes act as clock enables)
//            nRST       - asynchronous active-low reset
//            bus.slave  - strobes, frame control and result outputs
// Params   : ERR_DELAY  - bit_valid strobes between ACK slot end and the
//                         crc_error pulse (0..3)
//            ACK_EN     - 0 builds a listen-only node (ack_n held at 1)
// Revision : 1.0 - initial release
// ============================================================================
module can_crc_engine #(
  parameter int ERR_DELAY = 2,
  parameter bit ACK_EN    = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         nRST,
  can_crc_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DELIM = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // Internal mode encoding (mode 2'b11 is folded onto CRC-15 at SOF)
  localparam logic [1:0]  M_CRC15 = 2'd0;
  localparam logic [1:0]  M_CRC17 = 2'd1;
  localparam logic [1:0]  M_CRC21 = 2'd2;

  localparam logic [20:0] POLY15  = 21'h004599;
  localparam logic [20:0] POLY17  = 21'h01685B;
  localparam logic [20:0] POLY21  = 21'h102899;
  localparam logic [20:0] INIT15  = 21'h000000;
  localparam logic [20:0] INIT17  = 21'h010000;
  localparam logic [20:0] INIT21  = 21'h100000;

  // One serial CRC step; bits above the active width always come out 0.
  function automatic logic [20:0] crc_step(input logic [20:0] crc,
                                           input logic        din,
                                           input logic [1:0]  m);
    logic        inv;
    logic [20:0] nxt;
    inv = 1'b0;
    nxt = {crc[19:0], 1'b0};
    case (m)
      M_CRC17: begin
        inv = din ^ crc[16];
        nxt = nxt & 21'h01FFFF;
        if (inv) nxt = nxt ^ POLY17;
      end
      M_CRC21: begin
        inv = din ^ crc[20];
        if (inv) nxt = nxt ^ POLY21;
      end
      default: begin
        inv = din ^ crc[14];
        nxt = nxt & 21'h007FFF;
        if (inv) nxt = nxt ^ POLY15;
      end
    endcase
    return nxt;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [20:0] crc_q, crc_d;
  logic        match_q, match_d;
  logic        crc_ok_q, crc_ok_d;
  logic        ack_n_q, ack_n_d;
  logic        crc_err_q, crc_err_d;
  logic        delim_err_q, delim_err_d;
  logic        busy_q, busy_d;
  // Pending crc_error: flag plus remaining bit_valid count
  logic        pend_q, pend_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        w_shift_en;
  logic [1:0]  w_sof_mode;
  logic [20:0] w_sof_init;
  logic [20:0] w_step;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    crc_d       = crc_q;
    match_d     = match_q;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = 1'b0;
    delim_err_d = 1'b0;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    w_sof_mode  = M_CRC15;
    w_sof_init  = INIT15;

    // Classic frames exclude every stuff bit; FD frames only the fixed ones.
    if (mode_q == M_CRC15) begin
      w_shift_en = bus.bit_valid && !bus.stuff_bit;
    end else begin
      w_shift_en = bus.bit_valid && !(bus.stuff_bit && bus.fixed_stuff);
    end
    w_step = crc_step(crc_q, bus.rx_bit, mode_q);

    // Error delay runs independently of the frame state so a following
    // SOF does not disturb it.
    if (pend_q && bus.bit_valid) begin
      if (cnt_q == 2'd1) begin
        crc_err_d = 1'b1;
        pend_d    = 1'b0;
        cnt_d     = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.sof) begin
          case (bus.mode)
            2'b01:   begin w_sof_mode = M_CRC17; w_sof_init = INIT17; end
            2'b10:   begin w_sof_mode = M_CRC21; w_sof_init = INIT21; end
            default: begin w_sof_mode = M_CRC15; w_sof_init = INIT15; end
          endcase
          mode_d  = w_sof_mode;
          state_d = ST_RUN;
          crc_d   = bus.bit_valid ? crc_step(w_sof_init, bus.rx_bit, w_sof_mode)
                                  : w_sof_init;
        end
      end
      ST_RUN: begin
        if (w_shift_en) begin
          crc_d = w_step;
          if (bus.end_crc) begin
            state_d = ST_DELIM;
            match_d = (w_step == 21'd0);
          end
        end
      end
      ST_DELIM: begin
        // Delimiter sample first; a coincident tx_strobe still advances.
        if (bus.bit_valid && !bus.rx_bit) delim_err_d = 1'b1;
        if (bus.tx_strobe) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (bus.tx_strobe) begin
          state_d  = ST_IDLE;
          crc_ok_d = match_q;
          if (!match_q) begin
            if (ERR_DELAY == 0) begin
              crc_err_d = 1'b1;
            end else begin
              pend_d = 1'b1;
              cnt_d  = 2'(ERR_DELAY);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) begin
      state_d     = ST_IDLE;
      crc_d       = 21'd0;
      pend_d      = 1'b0;
      cnt_d       = 2'd0;
      crc_err_d   = 1'b0;
      delim_err_d = 1'b0;
    end

    ack_n_d = !((state_d == ST_ACK) && match_d && ACK_EN && !bus.listen_only);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      mode_q      <= M_CRC15;
      crc_q       <= 21'd0;
      match_q     <= 1'b0;
      crc_ok_q    <= 1'b0;
      ack_n_q     <= 1'b1;
      crc_err_q   <= 1'b0;
      delim_err_q <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      crc_q       <= crc_d;
      match_q     <= match_d;
      crc_ok_q    <= crc_ok_d;
      ack_n_q     <= ack_n_d;
      crc_err_q   <= crc_err_d;
      delim_err_q <= delim_err_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.ack_n       = ack_n_q;
  assign bus.crc_error   = crc_err_q;
  assign bus.delim_error = delim_err_q;
  assign bus.crc_ok      = crc_ok_q;
  assign bus.crc_value   = crc_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_can_crc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_crc_engine
// Purpose  : Directed self-checking bench for can_crc_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_crc_engine;

  logic clk  = 1'b0;
  logic nRST = 1'b0;
  always #5 clk = ~clk;

  can_crc_engine_if bus();

  can_crc_engine #(.ERR_DELAY(2), .ACK_EN(1'b1)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int err_pulses   = 0;
  int delim_pulses = 0;
  int ack_low      = 0;

  // Output activity counters, sampled shortly after each active edge
  always @(posedge clk) begin
    #2;
    if (bus.crc_error === 1'b1)   err_pulses++;
    if (bus.delim_error === 1'b1) delim_pulses++;
    if (bus.ack_n === 1'b0)       ack_low++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // One clock of strobes, applied at a falling edge; returns at the next
  // falling edge with the registered outputs already updated.
  task automatic cyc(input logic bv, input logic tx, input logic rx,
                     input logic st, input logic fx, input logic ec,
                     input logic sf, input logic ab);
    @(negedge clk);
    bus.bit_valid   = bv;
    bus.tx_strobe   = tx;
    bus.rx_bit      = rx;
    bus.stuff_bit   = st;
    bus.fixed_stuff = fx;
    bus.end_crc     = ec;
    bus.sof         = sf;
    bus.abort       = ab;
    @(negedge clk);
    bus.bit_valid   = 1'b0;
    bus.tx_strobe   = 1'b0;
    bus.rx_bit      = 1'b1;
    bus.stuff_bit   = 1'b0;
    bus.fixed_stuff = 1'b0;
    bus.end_crc     = 1'b0;
    bus.sof         = 1'b0;
    bus.abort       = 1'b0;
  endtask

  // Reference CRC, fed MSB first from bits[n-1] down to bits[0]
  function automatic logic [20:0] ref_crc(input logic [20:0] bits, input int n,
                                          input int w, input logic [20:0] poly,
                                          input logic [20:0] init);
    logic [20:0] r;
    logic [20:0] mask;
    logic        fb;
    r    = init;
    mask = (21'h1 << w) - 21'h1;
    for (int i = n - 1; i >= 0; i--) begin
      fb = bits[i] ^ r[w-1];
      r  = (r << 1) & mask;
      if (fb) r = r ^ poly;
    end
    return r;
  endfunction

  // Sends the 17-bit CRC-17 value MSB first, end_crc on the last bit
  task automatic send_crc17(input logic [16:0] v);
    for (int i = 16; i >= 0; i--) cyc(1, 0, v[i], 0, 0, (i == 0), 0, 0);
  endtask

  // 20-bit stream with an optional stuff bit after spos data bits
  task automatic run_stream(input logic [19:0] s, input logic [1:0] m,
                            input int spos, input logic sval, input logic sfx);
    bus.mode = m;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, s[19-i], 0, 0, (i == 19), (i == 0), 0);
      if (i + 1 == spos) begin
        // end_crc on an excluded bit must not close the CRC field
        cyc(1, 0, sval, 1, sfx, ((m == 2'b00) || sfx), 0, 0);
      end
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.ack_n !== 1'b1) begin tests_failed++; $display("FAIL reset_ack_n: got %b expected 1", bus.ack_n); end
    tests_run++;
    if (bus.crc_error !== 1'b0) begin tests_failed++; $display("FAIL reset_crc_error: got %b expected 0", bus.crc_error); end
    tests_run++;
    if (bus.delim_error !== 1'b0) begin tests_failed++; $display("FAIL reset_delim_error: got %b expected 0", bus.delim_error); end
    tests_run++;
    if (bus.crc_ok !== 1'b0) begin tests_failed++; $display("FAIL reset_crc_ok: got %b expected 0", bus.crc_ok); end
    tests_run++;
    if (bus.crc_value !== 21'h0) begin tests_failed++; $display("FAIL reset_crc_value: got %h expected 0", bus.crc_value); end
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
  endtask

  // CRC-15: SOF=1 gives 0x4599; next bit 1 gives inv=0, so 0x4599<<1
  // masked to 15 bits = 0x0B32 (no match).
  task automatic test_classic();
    int e0;
    bus.mode = 2'b00;
    ack_low  = 0;
    e0       = err_pulses;
    cyc(1, 0, 1, 0, 0, 0, 1, 0);
    tests_run++;
    if (bus.crc_value !== 21'h004599) begin tests_failed++; $display("FAIL classic_sof_crc: got %h expected 004599", bus.crc_value); end
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL classic_busy: got %b expected 1", bus.busy); end
    cyc(1, 0, 1, 0, 0, 1, 0, 0);
    tests_run++;
    if (bus.crc_value !== 21'h000B32) begin tests_failed++; $display("FAIL classic_end_crc: got %h expected 000B32", bus.crc_value); end
    cyc(1, 0, 1, 0, 0, 0, 0, 0);   // delimiter recessive
    cyc(0, 1, 1, 0, 0, 0, 0, 0);   // enter ACK
    tests_run++;
    if (bus.ack_n !== 1'b1) begin tests_failed++; $display("FAIL classic_ack_n: got %b expected 1", bus.ack_n); end
    cyc(0, 1, 1, 0, 0, 0, 0, 0);   // leave ACK
    tests_run++;
    if (bus.crc_ok !== 1'b0) begin tests_failed++; $display("FAIL classic_crc_ok: got %b expected 0", bus.crc_ok); end
    tests_run++;
    if (bus.crc_error !== 1'b0) begin tests_failed++; $display("FAIL classic_err_early0: got %b expected 0", bus.crc_error); end
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.crc_error !== 1'b0) begin tests_failed++; $display("FAIL classic_err_early1: got %b expected 0", bus.crc_error); end
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.crc_error !== 1'b1) begin tests_failed++; $display("FAIL classic_err_pulse: got %b expected 1", bus.crc_error); end
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (err_pulses - e0 !== 1) begin tests_failed++; $display("FAIL classic_err_count: got %0d expected 1", err_pulses - e0); end
    tests_run++;
    if (ack_low !== 0) begin tests_failed++; $display("FAIL classic_ack_cycles: got %0d expected 0", ack_low); end
  endtask

  // Valid CRC-17 frame; the delimiter bit and the ACK-entry tx_strobe share
  // a cycle. ACK is low from the entry strobe to the exit strobe (2 clocks).
  task automatic fd17_frame(input logic delim);
    bus.mode = 2'b01;
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    send_crc17(17'h1685B);
    cyc(1, 1, delim, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (4) cyc(1, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_fd17();
    int e0;
    bus.mode = 2'b01;
    ack_low  = 0;
    e0       = err_pulses;
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    tests_run++;
    if (bus.crc_value !== 21'h01685B) begin tests_failed++; $display("FAIL fd17_sof_crc: got %h expected 01685B", bus.crc_value); end
    send_crc17(17'h1685B);
    tests_run++;
    if (bus.crc_value !== 21'h0) begin tests_failed++; $display("FAIL fd17_final_crc: got %h expected 0", bus.crc_value); end
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.ack_n !== 1'b0) begin tests_failed++; $display("FAIL fd17_ack_drive: got %b expected 0", bus.ack_n); end
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.ack_n !== 1'b1) begin tests_failed++; $display("FAIL fd17_ack_release: got %b expected 1", bus.ack_n); end
    tests_run++;
    if (bus.crc_ok !== 1'b1) begin tests_failed++; $display("FAIL fd17_crc_ok: got %b expected 1", bus.crc_ok); end
    repeat (4) cyc(1, 0, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (ack_low !== 2) begin tests_failed++; $display("FAIL fd17_ack_cycles: got %0d expected 2", ack_low); end
    tests_run++;
    if (err_pulses - e0 !== 0) begin tests_failed++; $display("FAIL fd17_no_err: got %0d expected 0", err_pulses - e0); end
  endtask

  task automatic test_delim();
    int d0;
    ack_low = 0;
    d0      = delim_pulses;
    fd17_frame(1'b0);
    tests_run++;
    if (delim_pulses - d0 !== 1) begin tests_failed++; $display("FAIL delim_pulses: got %0d expected 1", delim_pulses - d0); end
    tests_run++;
    if (ack_low !== 2) begin tests_failed++; $display("FAIL delim_ack_cycles: got %0d expected 2", ack_low); end
    tests_run++;
    if (bus.crc_ok !== 1'b1) begin tests_failed++; $display("FAIL delim_crc_ok: got %b expected 1", bus.crc_ok); end
  endtask

  task automatic test_listen_only();
    int e0;
    bus.listen_only = 1'b1;
    ack_low = 0;
    e0      = err_pulses;
    fd17_frame(1'b1);
    bus.listen_only = 1'b0;
    tests_run++;
    if (ack_low !== 0) begin tests_failed++; $display("FAIL listen_ack_cycles: got %0d expected 0", ack_low); end
    tests_run++;
    if (bus.crc_ok !== 1'b1) begin tests_failed++; $display("FAIL listen_crc_ok: got %b expected 1", bus.crc_ok); end
    tests_run++;
    if (err_pulses - e0 !== 0) begin tests_failed++; $display("FAIL listen_no_err: got %0d expected 0", err_pulses - e0); end
  endtask

  // Mode 11 runs as CRC-15; a SOF seen in RUN is just another data bit.
  task automatic test_abort_run();
    bus.mode = 2'b11;
    cyc(1, 0, 1, 0, 0, 0, 1, 0);
    tests_run++;
    if (bus.crc_value !== 21'h004599) begin tests_failed++; $display("FAIL mode3_sof_crc: got %h expected 004599", bus.crc_value); end
    cyc(1, 0, 1, 0, 0, 0, 1, 0);
    tests_run++;
    if (bus.crc_value !== 21'h000B32) begin tests_failed++; $display("FAIL sof_in_run: got %h expected 000B32", bus.crc_value); end
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_run_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.crc_value !== 21'h0) begin tests_failed++; $display("FAIL abort_run_crc: got %h expected 0", bus.crc_value); end
    tests_run++;
    if (bus.crc_ok !== 1'b1) begin tests_failed++; $display("FAIL abort_run_crc_ok: got %b expected 1", bus.crc_ok); end
  endtask

  task automatic test_stuff();
    logic [19:0] s;
    logic [20:0] s_ext;
    logic [20:0] s_stf;
    logic [20:0] exp15;
    logic [20:0] exp21_dyn;
    logic [20:0] exp21_fix;
    s         = 20'h35A3C;
    s_ext     = {1'b0, s};
    s_stf     = {s[19:14], 1'b1, s[13:0]};
    exp15     = ref_crc(s_ext, 20, 15, 21'h004599, 21'h000000);
    exp21_dyn = ref_crc(s_stf, 21, 21, 21'h102899, 21'h100000);
    exp21_fix = ref_crc(s_ext, 20, 21, 21'h102899, 21'h100000);

    run_stream(s, 2'b00, 6, 1'b1, 1'b0);
    tests_run++;
    if (bus.crc_value !== exp15) begin tests_failed++; $display("FAIL stuff_classic: got %h expected %h", bus.crc_value, exp15); end
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL stuff_classic_busy: got %b expected 1", bus.busy); end
    cyc(0, 0, 1, 0, 0, 0, 0, 1);

    run_stream(s, 2'b10, 6, 1'b1, 1'b0);
    tests_run++;
    if (bus.crc_value !== exp21_dyn) begin tests_failed++; $display("FAIL stuff_fd21_dynamic: got %h expected %h", bus.crc_value, exp21_dyn); end
    cyc(0, 0, 1, 0, 0, 0, 0, 1);

    run_stream(s, 2'b10, 6, 1'b1, 1'b1);
    tests_run++;
    if (bus.crc_value !== exp21_fix) begin tests_failed++; $display("FAIL stuff_fd21_fixed: got %h expected %h", bus.crc_value, exp21_fix); end
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL stuff_abort_busy: got %b expected 0", bus.busy); end
  endtask

  // Failing classic frame, then abort after one of the two delay strobes.
  task automatic test_abort_delay();
    int e0;
    e0       = err_pulses;
    bus.mode = 2'b00;
    cyc(1, 0, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (bus.crc_ok !== 1'b0) begin tests_failed++; $display("FAIL abort_delay_crc_ok: got %b expected 0", bus.crc_ok); end
    cyc(1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 1);
    tests_run++;
    if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_delay_busy: got %b expected 0", bus.busy); end
    tests_run++;
    if (bus.crc_value !== 21'h0) begin tests_failed++; $display("FAIL abort_delay_crc: got %h expected 0", bus.crc_value); end
    repeat (5) cyc(1, 0, 1, 0, 0, 0, 0, 0);
    tests_run++;
    if (err_pulses - e0 !== 0) begin tests_failed++; $display("FAIL abort_delay_no_err: got %0d expected 0", err_pulses - e0); end
  endtask

  initial begin
    bus.bit_valid   = 1'b0;
    bus.tx_strobe   = 1'b0;
    bus.rx_bit      = 1'b1;
    bus.stuff_bit   = 1'b0;
    bus.fixed_stuff = 1'b0;
    bus.sof         = 1'b0;
    bus.end_crc     = 1'b0;
    bus.mode        = 2'b00;
    bus.abort       = 1'b0;
    bus.listen_only = 1'b0;
    nRST            = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    test_classic();
    test_fd17();
    test_delim();
    test_listen_only();
    test_abort_run();
    test_stuff();
    test_abort_delay();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
